// File: rtl/psum_pkg.sv
// Shared sizes, FSM state codes and saturation limits for the partial-sum collector.
// Build option PSUM_RELU_EN (see psum_collector.sv) does not affect this package.
package psum_pkg;
  localparam int NUM_PE   = 64;
  localparam int NUM_LANE = 14;
  localparam int IN_W     = 10;
  localparam int ACC_W    = 16;
  localparam int PASS_W   = 8;
  localparam int PE_W     = $clog2(NUM_PE);

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t ACCUM = 2'd1;
  localparam state_t DRAIN = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
endpackage

// File: rtl/psum_sat_add.sv
// One lane: sign-extend the incoming partial sum and add it to the accumulator,
// clamping to the signed accumulator range; first pass replaces the old value.
module psum_sat_add
  import psum_pkg::*;
(
  input  logic             first,
  input  logic [IN_W-1:0]  din,
  input  logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] sum
);
  logic [ACC_W:0] ext;
  logic [ACC_W:0] base;
  logic [ACC_W:0] s;

  always_comb begin
    ext  = {{(ACC_W+1-IN_W){din[IN_W-1]}}, din};
    base = first ? '0 : {acc[ACC_W-1], acc};
    s    = base + ext;
    // top two bits disagree only on overflow
    if (s[ACC_W] != s[ACC_W-1])
      sum = s[ACC_W] ? ACC_MIN : ACC_MAX;
    else
      sum = s[ACC_W-1:0];
  end
endmodule

// File: rtl/psum_collector.sv
// Accumulates N result-bus beats into saturating sums, then drains one PE per beat.
// Define PSUM_RELU_EN to clamp negative output lanes to zero at the output.
module psum_collector
  import psum_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PASS_W-1:0]               cfg_num_pass,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_PE*NUM_LANE*IN_W-1:0] in_result,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANE*ACC_W-1:0]       out_data,
  output logic [5:0]                      out_pe_idx,
  output logic                            out_last
);
  state_t                     state;
  logic [PASS_W-1:0]          pass_cnt;
  logic [PASS_W-1:0]          num_pass;
  logic [PASS_W-1:0]          eff_pass;
  logic [PE_W-1:0]            pe_idx;
  logic [PE_W-1:0]            nxt_pe;
  logic [NUM_LANE*ACC_W-1:0]  out_reg;
  logic [NUM_LANE*ACC_W-1:0]  row_next;
  logic [NUM_LANE*ACC_W-1:0]  row_first;
  logic [ACC_W-1:0]           acc [NUM_PE][NUM_LANE];
  logic [ACC_W-1:0]           sum [NUM_PE][NUM_LANE];
  logic                       accept;
  logic                       xfer;
  logic                       first;
  logic                       last_beat;

  assign in_ready   = (state != DRAIN);
  assign out_valid  = (state == DRAIN);
  assign accept     = in_valid & in_ready;
  assign xfer       = out_valid & out_ready;
  assign first      = (state == IDLE);
  assign nxt_pe     = pe_idx + PE_W'(1);
  assign out_pe_idx = pe_idx;
  assign out_last   = out_valid && (pe_idx == PE_W'(NUM_PE-1));

  always_comb begin
    eff_pass = first ? cfg_num_pass : num_pass;
    if (eff_pass == '0)
      eff_pass = PASS_W'(1);
  end

  assign last_beat = accept && (pass_cnt == eff_pass - PASS_W'(1));

  for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
    for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
      psum_sat_add u_add (
        .first (first),
        .din   (in_result[(p*NUM_LANE+l)*IN_W +: IN_W]),
        .acc   (acc[p][l]),
        .sum   (sum[p][l])
      );
    end
  end

  // PE0 is loaded from the adders so the first drain beat is ready at once
  always_comb begin
    row_next  = '0;
    row_first = '0;
    for (int l = 0; l < NUM_LANE; l++) begin
      row_next[l*ACC_W +: ACC_W]  = acc[nxt_pe][l];
      row_first[l*ACC_W +: ACC_W] = sum[0][l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PE; p++)
        for (int l = 0; l < NUM_LANE; l++)
          acc[p][l] <= '0;
    end else if (accept) begin
      for (int p = 0; p < NUM_PE; p++)
        for (int l = 0; l < NUM_LANE; l++)
          acc[p][l] <= sum[p][l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pass_cnt <= '0;
      num_pass <= PASS_W'(1);
      pe_idx   <= '0;
      out_reg  <= '0;
    end else begin
      unique case (1'b1)
        in_ready: begin
          if (accept) begin
            if (first)
              num_pass <= eff_pass;
            if (last_beat) begin
              state    <= DRAIN;
              pass_cnt <= '0;
              out_reg  <= row_first;
            end else begin
              state    <= ACCUM;
              pass_cnt <= pass_cnt + PASS_W'(1);
            end
          end
        end
        out_valid: begin
          if (xfer) begin
            if (out_last) begin
              state  <= IDLE;
              pe_idx <= '0;
            end else begin
              pe_idx  <= nxt_pe;
              out_reg <= row_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PSUM_RELU_EN
  always_comb begin
    out_data = '0;
    for (int l = 0; l < NUM_LANE; l++)
      out_data[l*ACC_W +: ACC_W] =
        out_reg[l*ACC_W+ACC_W-1] ? '0 : out_reg[l*ACC_W +: ACC_W];
  end
`else
  assign out_data = out_reg;
`endif
endmodule

// File: tb/tb_psum_collector.sv
// Randomized bench for psum_collector against a per-tile arithmetic model.
// Expectations follow PSUM_RELU_EN when the build defines it.
module tb_psum_collector;
  localparam int NP = 64;
  localparam int NL = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    cfg_num_pass = 8'd1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [8959:0] in_result = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [223:0]  out_data;
  logic [5:0]    out_pe_idx;
  logic          out_last;

  psum_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_num_pass (cfg_num_pass),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_pe_idx   (out_pe_idx),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [223:0] exp_q[$];
  int model_pe = 0;
  int macc[NP][NL];
  int ready_low = 0;
  logic [223:0] cap[NP];
  int cval = 0;
  int seq[4];
  bit bp_rand = 1'b0;

  task automatic chk(string n, longint a, longint e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask

  task automatic chk_vec(string n, logic [223:0] a, logic [223:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic int sat(int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int lane(logic [223:0] d, int l);
    logic signed [15:0] x;
    x = d[l*16 +: 16];
    return int'(x);
  endfunction

  function automatic int gen(int kind, int b, int p, int l);
    case (kind)
      0: return cval;
      1: return (p == 3 && l == 7) ? seq[b] : 0;
      3: return (p == 5 && l == 1) ? -10 : ((p == 5 && l == 2) ? 10 : 0);
      default: return int'($urandom_range(0, 1023)) - 512;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = bp_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Single compare point: every cycle outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      if (!in_ready) ready_low++;
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("in_ready", in_ready, exp_q.size() == 0);
      if (out_valid && exp_q.size() != 0) begin
        chk_vec("out_data", out_data, exp_q[0]);
        chk("out_pe_idx", out_pe_idx, model_pe);
        chk("out_last", out_last, model_pe == NP-1);
        cap[out_pe_idx] = out_data;
        if (out_ready) begin
          void'(exp_q.pop_front());
          model_pe = (model_pe + 1) % NP;
        end
      end
    end
  end

  task automatic wait_ready();
    int g = 0;
    @(negedge clk);
    while (!in_ready) begin
      g++;
      if (g > 500) begin
        chk("accept_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain_wait();
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
      in_valid  = ($urandom_range(0, 1) == 1);
      in_result = {280{$urandom}};
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    in_valid = 1'b0;
  endtask

  task automatic run_tile(int cfg, int kind, bit wait_drain, int stop_after);
    int n;
    int v;
    logic [223:0] e;
    n = (cfg == 0) ? 1 : cfg;
    cfg_num_pass = 8'(cfg);
    for (int b = 0; b < n; b++) begin
      if (stop_after > 0 && b == stop_after) return;
      if (kind == 2 && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      for (int p = 0; p < NP; p++)
        for (int l = 0; l < NL; l++) begin
          v = gen(kind, b, p, l);
          in_result[(p*NL+l)*10 +: 10] = 10'(v);
          macc[p][l] = (b == 0) ? v : sat(macc[p][l] + v);
        end
      in_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (kind == 2) cfg_num_pass = 8'($urandom);
    end
    for (int p = 0; p < NP; p++) begin
      e = '0;
      for (int l = 0; l < NL; l++) begin
        v = macc[p][l];
`ifdef PSUM_RELU_EN
        if (v < 0) v = 0;
`endif
        e[l*16 +: 16] = 16'(v);
      end
      exp_q.push_back(e);
    end
    if (wait_drain) drain_wait();
  endtask

  task automatic chk_idle_outputs(string n);
    chk({n, "_valid"}, out_valid, 0);
    chk({n, "_ready"}, in_ready, 1);
    chk({n, "_idx"}, out_pe_idx, 0);
    chk({n, "_last"}, out_last, 0);
    chk_vec({n, "_data"}, out_data, '0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk_idle_outputs("reset");

    ready_low = 0;
    cval = 5;
    run_tile(1, 0, 1, 0);
    chk("ready_low_cycles", ready_low, 64);
    chk("t1_pe0_l0", lane(cap[0], 0), 5);
    chk("t1_pe63_l13", lane(cap[63], 13), 5);

    seq[0] = 100; seq[1] = -30; seq[2] = 7; seq[3] = -1;
    run_tile(4, 1, 1, 0);
    chk("t2_pe3_l7", lane(cap[3], 7), 76);
    chk("t2_pe3_l6", lane(cap[3], 6), 0);
    chk("t2_pe4_l7", lane(cap[4], 7), 0);

    cval = 511;
    run_tile(200, 0, 1, 0);
    chk("sat_pos", lane(cap[10], 2), 32767);
    cval = -512;
    run_tile(70, 0, 1, 0);
`ifdef PSUM_RELU_EN
    chk("sat_neg", lane(cap[63], 13), 0);
`else
    chk("sat_neg", lane(cap[63], 13), -32768);
`endif

    run_tile(2, 3, 1, 0);
`ifdef PSUM_RELU_EN
    chk("relu_neg", lane(cap[5], 1), 0);
`else
    chk("relu_neg", lane(cap[5], 1), -20);
`endif
    chk("relu_pos", lane(cap[5], 2), 20);

    bp_rand = 1'b1;
    for (int t = 0; t < 5; t++)
      run_tile(int'($urandom_range(0, 5)), 2, 1, 0);

    run_tile(4, 2, 0, 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rst_acc");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cval = 3;
    run_tile(1, 0, 1, 0);
    chk("fresh_pe20_l4", lane(cap[20], 4), 3);
    chk("fresh_pe63_l0", lane(cap[63], 0), 3);

    cval = 7;
    run_tile(1, 0, 0, 0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rst_drain");
    exp_q.delete();
    model_pe = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_tile(2, 2, 1, 0);
    bp_rand = 1'b0;

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Consumer end of the computing-core result bus.
- Each input beat is 64 PEs x 14 lanes x 10-bit signed partial sums, covering one 8-channel group.
- The block accumulates a configurable number of beats (channel groups) into 16-bit saturating accumulators.
- It then drains the finished sums one PE per beat over a valid/ready stream to the output buffer / write-back stage.

Parameters:
- NUM_PE, 64, PEs per input beat.
- NUM_LANE, 14, MAC lanes per PE.
- IN_W, 10, signed width of each incoming lane partial sum.
- ACC_W, 16, signed accumulator / output lane width.
- PASS_W, 8, width of the pass-count configuration.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_num_pass  in  PASS_W  number of input beats per output tile; sampled on the first accepted beat of a tile.
- in_valid  in  1  in_result holds a valid beat.
- in_ready  out  1  collector can accept a beat.
- in_result  in  NUM_PE*NUM_LANE*IN_W (8960)  packed partial sums; PE p, lane l sits at bits [(p*NUM_LANE+l)*IN_W +: IN_W].
- out_valid  out  1  out_data holds one PE's finished sums.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  NUM_LANE*ACC_W (224)  lane l at bits [l*ACC_W +: ACC_W].
- out_pe_idx  out  6  index of the PE carried in out_data.
- out_last  out  1  high on the beat with out_pe_idx == NUM_PE-1.

Behaviour:
- States and transitions:
  - IDLE: in_ready=1; the first accepted beat goes to ACCUM, or to DRAIN if the latched pass count is 1.
  - ACCUM: in_ready=1.
  - DRAIN: in_ready=0, out_valid=1.
- Handshakes:
  - Input beat accepted when in_valid & in_ready on a rising edge.
  - Output beat transferred when out_valid & out_ready.
- Pass count: cfg_num_pass is latched on the first accepted beat of a tile; a latched value of 0 is treated as 1.
- pass_cnt:
  - Starts at 0 and increments on each accepted beat.
  - When a beat is accepted with pass_cnt == latched-1, the next state is DRAIN and pass_cnt clears.
- Accumulation per lane:
  - First beat: acc = sign_extend(in).
  - Later beats: acc = sat(acc + sign_extend(in)), clamped to [-32768, 32767]; no wrap.
- Latency: the last input beat is accepted at edge N; out_valid is high after edge N (first drain beat in cycle N+1).
- Drain:
  - out_data = acc[pe_idx], registered.
  - On each transfer, pe_idx increments.
  - A transfer with out_last goes to IDLE, clears pe_idx and drops out_valid on the next cycle.
- Stalls: out_valid=1 & out_ready=0 holds out_data / out_pe_idx / out_last stable indefinitely.
- Input while draining: in_valid during DRAIN is ignored (in_ready=0); there is no overlap between tiles.
- Back-to-back tiles: a new tile can be accepted the cycle after the last drain transfer.
- Reset (async, any state, including mid-accumulate or mid-drain):
  - state=IDLE; pass_cnt=0; pe_idx=0.
  - out_valid=0, out_data=0, out_pe_idx=0, out_last=0, in_ready=1 after reset deasserts.
  - Accumulators cleared to 0.
  - Partial tile discarded.

Optional Feature:
- PSUM_RELU_EN defined: each out_data lane is max(acc, 0) at output, applied combinationally on the registered drain value; accumulators are unchanged.
- Undefined: out_data is the raw signed accumulator.

Decomposition:
- Package psum_pkg holds:
  - NUM_PE, NUM_LANE, IN_W, ACC_W defaults;
  - the state enum {IDLE, ACCUM, DRAIN};
  - the ACC_MAX / ACC_MIN constants.
- Sub-module psum_sat_add: one lane, IN_W + ACC_W -> ACC_W saturating signed add with a first-pass select; instantiated NUM_PE*NUM_LANE times via generate.

Test Plan:
- cfg=1, all lanes = 10'sd5, out_ready=1 -> 64 beats, every lane 5, pe_idx 0..63, out_last only on beat 63, in_ready low for exactly 64 cycles.
- cfg=4, PE3 lane7 = +100, -30, +7, -1 -> that lane reads 76; all other lanes (input 0) read 0.
- Saturation:
  - cfg=200, all lanes +511 -> every lane 32767.
  - All lanes -512 -> -32768.
- Backpressure: out_ready toggling 1/0 with a random pattern -> no PE skipped or repeated; data stable while stalled; in_valid pulsed during drain has no effect.
- Reset: rst_n low during pass 2 of 4, then a fresh cfg=1 tile of all 3s -> outputs read 3 (no stale sums); rst_n low mid-drain -> out_valid=0 immediately.
- Optional feature: with PSUM_RELU_EN, a lane accumulating to -20 outputs 0 and +20 outputs 20; without it, the lane outputs -20.
